// File: rtl/tdc_gpx_pkg.sv
// ---------------------------------------------------------------------------
// tdc_gpx_pkg
// Shared definitions for the TDC-GPX power-up configuration sequencer:
//   - tdc_state_e   : sequencer state encoding
//   - ADDR_REGn     : TDC register addresses written during configuration
//   - DEF_REGn      : default configuration words (used as parameter defaults)
//   - LAST_INDEX    : table index of the final configuration write
// ---------------------------------------------------------------------------
package tdc_gpx_pkg;

  // One write cycle walks SETUP -> SEL -> STROBE -> HOLD; WAIT precedes the
  // table and DONE follows it.
  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SEL    = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } tdc_state_e;

  // TDC register addresses touched by the configuration table.
  localparam logic [3:0] ADDR_REG0  = 4'd0;
  localparam logic [3:0] ADDR_REG1  = 4'd1;
  localparam logic [3:0] ADDR_REG2  = 4'd2;
  localparam logic [3:0] ADDR_REG3  = 4'd3;
  localparam logic [3:0] ADDR_REG4  = 4'd4;
  localparam logic [3:0] ADDR_REG5  = 4'd5;
  localparam logic [3:0] ADDR_REG6  = 4'd6;
  localparam logic [3:0] ADDR_REG7  = 4'd7;
  localparam logic [3:0] ADDR_REG11 = 4'd11;
  localparam logic [3:0] ADDR_REG12 = 4'd12;
  localparam logic [3:0] ADDR_REG14 = 4'd14;

  // Default configuration words.
  localparam logic [27:0] DEF_REG0  = 28'h007FC81;
  localparam logic [27:0] DEF_REG1  = 28'h0000000;
  localparam logic [27:0] DEF_REG2  = 28'h0000002;
  localparam logic [27:0] DEF_REG3  = 28'h0000000;
  localparam logic [27:0] DEF_REG4  = 28'h6000000;
  localparam logic [27:0] DEF_REG5  = 28'h0E004DA;
  localparam logic [27:0] DEF_REG6  = 28'h0000000;
  localparam logic [27:0] DEF_REG7  = 28'h0001FB4;
  localparam logic [27:0] DEF_REG11 = 28'h7FF0000;
  localparam logic [27:0] DEF_REG12 = 28'h2000000;
  localparam logic [27:0] DEF_REG14 = 28'h0000000;

  // Eleven table entries, indices 0..10.
  localparam logic [3:0] LAST_INDEX = 4'd10;

endpackage

// File: rtl/tdc_initial.sv
// ---------------------------------------------------------------------------
// tdc_initial
// Power-up configuration sequencer for a TDC-GPX style time-to-digital
// converter. After reset release it waits WAIT_CYCLES clocks, writes eleven
// configuration words over the parallel bus (4 cycles each), then enables
// the stop channels and raises a sticky done flag.
//
// Ports:
//   clk                 in   system clock, rising edge
//   reset_n             in   asynchronous active-low reset
//   WRN                 out  write strobe, active low
//   CSN                 out  chip select, active low
//   addr[3:0]           out  TDC register address
//   data[27:0]          out  TDC register write data
//   flag                out  configuration complete (sticky until reset)
//   StopDis1..StopDis4  out  stop-channel disables, 1 = disabled
// All outputs are driven directly from registers.
// ---------------------------------------------------------------------------
module tdc_initial
  import tdc_gpx_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 8,
  parameter logic [27:0] REG0  = DEF_REG0,
  parameter logic [27:0] REG1  = DEF_REG1,
  parameter logic [27:0] REG2  = DEF_REG2,
  parameter logic [27:0] REG3  = DEF_REG3,
  parameter logic [27:0] REG4  = DEF_REG4,
  parameter logic [27:0] REG5  = DEF_REG5,
  parameter logic [27:0] REG6  = DEF_REG6,
  parameter logic [27:0] REG7  = DEF_REG7,
  parameter logic [27:0] REG11 = DEF_REG11,
  parameter logic [27:0] REG12 = DEF_REG12,
  parameter logic [27:0] REG14 = DEF_REG14
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        WRN,
  output logic        CSN,
  output logic [3:0]  addr,
  output logic [27:0] data,
  output logic        flag,
  output logic        StopDis1,
  output logic        StopDis2,
  output logic        StopDis3,
  output logic        StopDis4
);

  tdc_state_e  state_q, state_d;
  logic [31:0] waitCnt_q, waitCnt_d;
  logic [3:0]  idx_q, idx_d;

  logic        wrn_q, wrn_d;
  logic        csn_q, csn_d;
  logic [3:0]  addr_q, addr_d;
  logic [27:0] data_q, data_d;
  logic        flag_q, flag_d;
  logic [3:0]  stopDis_q, stopDis_d;

  // Configuration table: index -> {address, data}.
  function automatic logic [31:0] romEntry(input logic [3:0] index);
    logic [31:0] entry;
    case (index)
      4'd0:    entry = {ADDR_REG0,  REG0};
      4'd1:    entry = {ADDR_REG1,  REG1};
      4'd2:    entry = {ADDR_REG2,  REG2};
      4'd3:    entry = {ADDR_REG3,  REG3};
      4'd4:    entry = {ADDR_REG4,  REG4};
      4'd5:    entry = {ADDR_REG5,  REG5};
      4'd6:    entry = {ADDR_REG6,  REG6};
      4'd7:    entry = {ADDR_REG7,  REG7};
      4'd8:    entry = {ADDR_REG11, REG11};
      4'd9:    entry = {ADDR_REG12, REG12};
      default: entry = {ADDR_REG14, REG14};
    endcase
    return entry;
  endfunction

  // Sequencer next-state logic. WAIT holds until the counter has seen
  // WAIT_CYCLES edges, so the first SETUP cycle is cycle WAIT_CYCLES
  // counted from the first edge after reset release.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    idx_d     = idx_q;
    case (state_q)
      ST_WAIT: begin
        if (waitCnt_q >= WAIT_CYCLES) begin
          state_d = ST_SETUP;
          idx_d   = 4'd0;
        end else begin
          waitCnt_d = waitCnt_q + 32'd1;
        end
      end
      ST_SETUP:  state_d = ST_SEL;
      ST_SEL:    state_d = ST_STROBE;
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (idx_q == LAST_INDEX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_SETUP;
        end
      end
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_WAIT;
    endcase
  end

  // Output next values are decoded from the next state so every output can
  // be a flop yet still line up with the state it belongs to. addr/data are
  // only reloaded on entry to SETUP, which keeps them frozen while CSN is low
  // and leaves the last written pair on the bus in DONE.
  always_comb begin
    csn_d     = !((state_d == ST_SEL) || (state_d == ST_STROBE) ||
                  (state_d == ST_HOLD));
    wrn_d     = (state_d != ST_STROBE);
    addr_d    = addr_q;
    data_d    = data_q;
    if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) begin
      {addr_d, data_d} = romEntry(idx_d);
    end
    flag_d    = (state_d == ST_DONE);
    stopDis_d = (state_d == ST_DONE) ? 4'b0000 : 4'b1111;
  end

  // State, counters and output registers; reset drops the bus to idle at
  // once and abandons any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_WAIT;
      waitCnt_q <= 32'd0;
      idx_q     <= 4'd0;
      wrn_q     <= 1'b1;
      csn_q     <= 1'b1;
      addr_q    <= 4'd0;
      data_q    <= 28'd0;
      flag_q    <= 1'b0;
      stopDis_q <= 4'b1111;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      idx_q     <= idx_d;
      wrn_q     <= wrn_d;
      csn_q     <= csn_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      flag_q    <= flag_d;
      stopDis_q <= stopDis_d;
    end
  end

  assign WRN      = wrn_q;
  assign CSN      = csn_q;
  assign addr     = addr_q;
  assign data     = data_q;
  assign flag     = flag_q;
  assign StopDis1 = stopDis_q[0];
  assign StopDis2 = stopDis_q[1];
  assign StopDis3 = stopDis_q[2];
  assign StopDis4 = stopDis_q[3];

endmodule

// File: tb/tb_tdc_initial.sv
// ---------------------------------------------------------------------------
// tb_tdc_initial
// Directed bench for tdc_initial. Two instances share clock and reset: one
// with default parameters, one with WAIT_CYCLES=2 and REG5=28'h1234567.
// Outputs are sampled on the falling clock edge and compared against a
// cycle model built from the write table.
// ---------------------------------------------------------------------------
module tb_tdc_initial;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  // 50 MHz clock.
  always #10 clk = ~clk;

  logic        wrnA, csnA, flagA, s1A, s2A, s3A, s4A;
  logic [3:0]  addrA;
  logic [27:0] dataA;
  logic        wrnB, csnB, flagB, s1B, s2B, s3B, s4B;
  logic [3:0]  addrB;
  logic [27:0] dataB;

  tdc_initial dutA (
    .clk(clk), .reset_n(reset_n), .WRN(wrnA), .CSN(csnA), .addr(addrA),
    .data(dataA), .flag(flagA), .StopDis1(s1A), .StopDis2(s2A),
    .StopDis3(s3A), .StopDis4(s4A)
  );

  tdc_initial #(.WAIT_CYCLES(2), .REG5(28'h1234567)) dutB (
    .clk(clk), .reset_n(reset_n), .WRN(wrnB), .CSN(csnB), .addr(addrB),
    .data(dataB), .flag(flagB), .StopDis1(s1B), .StopDis2(s2B),
    .StopDis3(s3B), .StopDis4(s4B)
  );

  int total = 0;
  int bad = 0;
  int pulsesA = 0;
  int pulsesB = 0;

  localparam logic [38:0] RESET_VEC = {1'b1, 1'b1, 4'h0, 28'h0, 1'b0, 4'b1111};

  function automatic logic [3:0] tblAddr(input int j);
    case (j)
      0: return 4'h0;  1: return 4'h1;  2: return 4'h2;  3: return 4'h3;
      4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'h7;
      8: return 4'hB;  9: return 4'hC;  default: return 4'hE;
    endcase
  endfunction

  function automatic logic [27:0] tblData(input int j, input logic [27:0] r5);
    case (j)
      0: return 28'h007FC81;  1: return 28'h0000000;  2: return 28'h0000002;
      3: return 28'h0000000;  4: return 28'h6000000;  5: return r5;
      6: return 28'h0000000;  7: return 28'h0001FB4;  8: return 28'h7FF0000;
      9: return 28'h2000000;  default: return 28'h0000000;
    endcase
  endfunction

  // Expected {WRN,CSN,addr,data,flag,StopDis4..1} for cycle c after release.
  function automatic logic [38:0] model(input int c, input int w, input logic [27:0] r5);
    int j, ph;
    if (c < w) return RESET_VEC;
    if (c >= w + 44) return {1'b1, 1'b1, 4'hE, 28'h0, 1'b1, 4'b0000};
    j  = (c - w) / 4;
    ph = (c - w) % 4;
    return {(ph != 2), (ph == 0), tblAddr(j), tblData(j, r5), 1'b0, 4'b1111};
  endfunction

  function automatic logic [38:0] obsA();
    return {wrnA, csnA, addrA, dataA, flagA, s4A, s3A, s2A, s1A};
  endfunction

  function automatic logic [38:0] obsB();
    return {wrnB, csnB, addrB, dataB, flagB, s4B, s3B, s2B, s1B};
  endfunction

  // Compare both instances against the model for cycle c.
  task automatic checkOutput(input int c);
    logic [38:0] expA, expB, gotA, gotB;
    expA = model(c, 8, 28'h0E004DA);
    expB = model(c, 2, 28'h1234567);
    gotA = obsA();
    gotB = obsB();
    if (gotA[38] === 1'b0) pulsesA++;
    if (gotB[38] === 1'b0) pulsesB++;
    total++;
    assert (gotA === expA) else begin
      bad++;
      $error("[TB] FAIL seqA cycle=%0d got=%h exp=%h", c, gotA, expA);
    end
    total++;
    assert (gotB === expB) else begin
      bad++;
      $error("[TB] FAIL seqB cycle=%0d got=%h exp=%h", c, gotB, expB);
    end
  endtask

  task automatic checkReset(input string tag);
    logic [38:0] gotA, gotB;
    gotA = obsA();
    gotB = obsB();
    total++;
    assert (gotA === RESET_VEC) else begin
      bad++;
      $error("[TB] FAIL %s A got=%h exp=%h", tag, gotA, RESET_VEC);
    end
    total++;
    assert (gotB === RESET_VEC) else begin
      bad++;
      $error("[TB] FAIL %s B got=%h exp=%h", tag, gotB, RESET_VEC);
    end
  endtask

  task automatic checkPulses(input string tag);
    total++;
    assert (pulsesA === 11) else begin
      bad++;
      $error("[TB] FAIL %s A wrn pulses got=%0d exp=11", tag, pulsesA);
    end
    total++;
    assert (pulsesB === 11) else begin
      bad++;
      $error("[TB] FAIL %s B wrn pulses got=%0d exp=11", tag, pulsesB);
    end
  endtask

  // Run n cycles after a release on a falling edge, checking every cycle.
  task automatic applyStimulus(input int n);
    pulsesA = 0;
    pulsesB = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput(c);
    end
  endtask

  initial begin
    // Reset held for 200 ns.
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #20;
      checkReset("resetHold");
    end

    // Full sequence, then 250 more cycles (5000 ns) in DONE.
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(52 + 250);
    checkPulses("fullSeq");

    // Restart and break into the 5th write of the default instance.
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    checkReset("restart");
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(26);
    #3;
    reset_n = 1'b0;
    #1;
    checkReset("midReset");
    @(posedge clk);
    #1;
    checkReset("midResetHeld");

    // Sequence must restart cleanly from address 0.
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(60);
    checkPulses("afterMidReset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
